serial_sub8: RTL and testbench



---
 rtl/serial_sub8.sv | 112 +++++++++++
 tb/tb_serial_sub8.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_sub8.sv
// serial_sub8: bit-serial subtractor, one full-subtractor cell, LSB first.
// Computes a - b - bin over WIDTH cycles with a start/ready/done handshake.
module serial_sub8 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE = CW'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0] a_sr, b_sr, res;
   logic [CW-1:0]    cnt;
   logic             br;

   logic             ai, bi, d, br_nx, last;
   logic [WIDTH-1:0] res_nx;

   // full-subtractor cell on the current LSBs
   always_comb begin
      ai     = a_sr[0];
      bi     = b_sr[0];
      d      = ai ^ bi ^ br;
      br_nx  = (~ai & bi) | (~(ai ^ bi) & br);
      res_nx = {d, res[WIDTH-1:1]};
      last   = (cnt == LAST);
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next state and handshake outputs
   always_comb begin
      state_nx = state;
      ready    = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) state_nx = RUN;
         end
         RUN: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // operand shifters, borrow, counter and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr <= '0;
         b_sr <= '0;
         res  <= '0;
         cnt  <= '0;
         br   <= 1'b0;
         diff <= '0;
         bout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr <= a;
                  b_sr <= b;
                  br   <= bin;
                  cnt  <= '0;
               end
            end
            RUN: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               res  <= res_nx;
               br   <= br_nx;
               if (last) begin
                  cnt  <= '0;
                  diff <= res_nx;
                  bout <= br_nx;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub8.sv
// tb_serial_sub8: directed and random checks of serial_sub8.
// Expected values come from hand tables and 9-bit arithmetic.
module tb_serial_sub8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] a, b;
   logic       bin;
   logic       ready, done;
   logic [7:0] diff;
   logic       bout;

   int errors = 0;
   int checks = 0;

   serial_sub8 #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .ready (ready),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one operation from an IDLE point; optional start/operand glitches
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                         input logic tbin, input bit glitch,
                         input string tag);
      logic [8:0] r;
      int n;
      r = {1'b0, ta} - {1'b0, tb} - {8'd0, tbin};
      n = 0;
      while (!ready && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_rdy"}, {31'd0, ready}, 32'd1);
      a = ta;
      b = tb;
      bin = tbin;
      start = 1'b1;
      step();
      start = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      bin = 1'($urandom);
      n = 0;
      while (!done && n < 20) begin
         if (glitch) begin
            start = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            bin = 1'($urandom);
         end
         step();
         n++;
      end
      start = 1'b0;
      chk({tag, "_lat"}, n, 32'd8);
      chk({tag, "_diff"}, {24'd0, diff}, {24'd0, r[7:0]});
      chk({tag, "_bout"}, {31'd0, bout}, {31'd0, r[8]});
      step();
      chk({tag, "_rdy_after"}, {30'd0, ready, done}, 32'd2);
   endtask

   initial begin
      int dcount;
      logic [8:0] r;
      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      bin = 1'b0;
      #12;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_diff", {24'd0, diff}, 32'd0);
      chk("rst_bout", {31'd0, bout}, 32'd0);
      rst_n = 1'b1;
      step();

      run_op(8'h6A, 8'hBD, 1'b0, 0, "op_6a_bd");
      run_op(8'hBD, 8'h6A, 1'b0, 0, "op_bd_6a");
      run_op(8'h00, 8'h00, 1'b1, 0, "op_00_00_b");
      run_op(8'hFF, 8'hFF, 1'b0, 0, "op_ff_ff");
      chk("ff_diff_lit", {24'd0, diff}, 32'h00);

      // start asserted during RUN and DONE must be ignored
      a = 8'h10;
      b = 8'h01;
      bin = 1'b0;
      start = 1'b1;
      step();
      a = 8'h00;
      b = 8'hFF;
      dcount = 0;
      for (int t = 1; t <= 9; t++) begin
         step();
         if (done) begin
            dcount++;
            chk("ign_t", t, 8);
            chk("ign_diff", {24'd0, diff}, 32'h0F);
            chk("ign_bout", {31'd0, bout}, 32'd0);
         end
      end
      start = 1'b0;
      for (int t = 0; t < 15; t++) begin
         step();
         if (done) dcount++;
      end
      chk("ign_single_done", dcount, 1);
      chk("ign_hold_diff", {24'd0, diff}, 32'h0F);

      // start held high for three back-to-back operations
      a = 8'h6A;
      b = 8'hBD;
      bin = 1'b0;
      start = 1'b1;
      step();
      a = 8'h50;
      b = 8'h20;
      bin = 1'b1;
      for (int t = 1; t <= 30; t++) begin
         step();
         if (t == 10) begin
            a = 8'h05;
            b = 8'h07;
            bin = 1'b0;
         end
         if (t == 20) start = 1'b0;
         chk("hold_done", {31'd0, done},
             {31'd0, (t == 8 || t == 18 || t == 28)});
         if (t == 8 || t == 12)
            chk("hold_r1", {23'd0, bout, diff}, 32'h1AD);
         if (t == 18 || t == 22)
            chk("hold_r2", {23'd0, bout, diff}, 32'h02F);
         if (t == 28 || t == 30)
            chk("hold_r3", {23'd0, bout, diff}, 32'h1FE);
      end

      // asynchronous reset in the middle of RUN
      a = 8'h33;
      b = 8'h11;
      bin = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ready", {31'd0, ready}, 32'd1);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_diff", {24'd0, diff}, 32'd0);
      chk("arst_bout", {31'd0, bout}, 32'd0);
      #3;
      rst_n = 1'b1;
      step();
      run_op(8'h80, 8'h01, 1'b0, 0, "after_rst");
      chk("after_rst_lit", {23'd0, bout, diff}, 32'h07F);

      // random operations with gaps and mid-operation glitches
      for (int i = 0; i < 1000; i++) begin
         r[7:0] = 8'($urandom);
         run_op(r[7:0], 8'($urandom), 1'($urandom), 1'($urandom), "rnd");
         repeat ($urandom_range(0, 3)) step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
